// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider using restoring shift-subtract, one quotient bit per clock.
// Define QDIV_ROUND_EN to compute a guard bit and round half up on magnitude (one extra cycle).
module qdiv_seq #(
    parameter int unsigned Q = 15,
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         div_by_zero
);

`ifdef QDIV_ROUND_EN
    localparam int unsigned GUARD = 1;
`else
    localparam int unsigned GUARD = 0;
`endif
    localparam int unsigned TW    = N - 1 + Q;
    localparam int unsigned ITERS = TW + GUARD;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [ITERS-1:0] num;
    logic [ITERS-1:0] qreg;
    logic [N-1:0]     rem;
    logic [N-2:0]     dvs;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             dz_r;

    logic             accept;
    logic [N-1:0]     rem_sh;
    logic [N-1:0]     rem_nx;
    logic             ge;
    logic [TW:0]      rq;
    logic             res_ovf;
    logic [N-2:0]     res_mag;
    logic             res_sign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, one restoring iteration and result formation
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (divisor[N-2:0] == '0) ? DONE : CALC;
                end
            end
            CALC:    if (cnt == CW'(ITERS - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        rem_sh = {rem[N-2:0], num[ITERS-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;

`ifdef QDIV_ROUND_EN
        rq = {1'b0, qreg[ITERS-1:1]} + (TW+1)'(qreg[0]);
`else
        rq = {1'b0, qreg};
`endif
        res_ovf = 1'b0;
        res_mag = rq[N-2:0];
        if (dz_r) begin
            res_mag = '1;
        end else if (|rq[TW:N-1]) begin
            res_ovf = 1'b1;
            res_mag = '1;
        end
        // Zero magnitude is always reported positive
        res_sign = sign & (res_mag != '0);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num         <= '0;
            qreg        <= '0;
            rem         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                sign        <= dividend[N-1] ^ divisor[N-1];
                num         <= ITERS'(dividend[N-2:0]) << (ITERS - (N - 1));
                dvs         <= divisor[N-2:0];
                dz_r        <= (divisor[N-2:0] == '0);
                rem         <= '0;
                qreg        <= '0;
                cnt         <= '0;
                busy        <= 1'b1;
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
            end else if (state == CALC) begin
                rem  <= rem_nx;
                qreg <= {qreg[ITERS-2:0], ge};
                num  <= num << 1;
                cnt  <= cnt + CW'(1);
            end else if (state == DONE) begin
                quotient    <= {res_sign, res_mag};
                overflow    <= res_ovf;
                div_by_zero <= dz_r;
                busy        <= 1'b0;
            end
        end
    end

endmodule
